// File: rtl/ddr_axi_write_master_enc.sv
// Encoder DDR write master: buffers controller FIFO pops and issues one AXI4 INCR burst per request.
// Optional macro WR_RESP_ERR_CNT_EN enables the saturating non-OKAY write-response counter.
module ddr_axi_write_master_enc #(
    parameter int g_DDR_AXI_AWIDTH = 32,
    parameter int g_DDR_AXI_DWIDTH = 64,
    parameter int g_AXI_IDWIDTH    = 4,
    parameter int g_AXI_ID         = 0,
    parameter int g_BUF_DEPTH      = 512
) (
    input  logic                        sys_clk_i,
    input  logic                        reset_i,
    input  logic                        write_req_i,
    input  logic [g_DDR_AXI_AWIDTH-1:0] write_start_addr_i,
    input  logic [7:0]                  write_length_i,
    output logic                        write_ackn_o,
    output logic                        write_done_o,
    input  logic [g_DDR_AXI_DWIDTH-1:0] fifo_rdata_i,
    input  logic                        fifo_rvalid_i,
    output logic [g_AXI_IDWIDTH-1:0]    awid_o,
    output logic [g_DDR_AXI_AWIDTH-1:0] awaddr_o,
    output logic [7:0]                  awlen_o,
    output logic [2:0]                  awsize_o,
    output logic [1:0]                  awburst_o,
    output logic                        awvalid_o,
    input  logic                        awready_i,
    output logic [g_DDR_AXI_DWIDTH-1:0] wdata_o,
    output logic [g_DDR_AXI_DWIDTH/8-1:0] wstrb_o,
    output logic                        wlast_o,
    output logic                        wvalid_o,
    input  logic                        wready_i,
    input  logic [g_AXI_IDWIDTH-1:0]    bid_i,
    input  logic [1:0]                  bresp_i,
    input  logic                        bvalid_i,
    output logic                        bready_o,
    output logic                        busy_o,
    output logic                        buf_ovf_o,
    output logic [15:0]                 resp_err_cnt_o
);
    localparam int PW = $clog2(g_BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                        state_q;
    logic [g_DDR_AXI_AWIDTH-1:0]   addr_q;
    logic [7:0]                    len_q;
    logic [7:0]                    beat_q;
    logic                          ackn_q, done_q, awvalid_q, bready_q, ovf_q;

    logic [g_DDR_AXI_DWIDTH-1:0]   mem_q [g_BUF_DEPTH];
    logic [PW-1:0]                 wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                 cnt_q, free, need;
    logic                          empty, full, push, pop;
    logic                          unused_in;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(g_BUF_DEPTH));
    assign free  = CW'(g_BUF_DEPTH) - cnt_q;
    assign need  = CW'(write_length_i) + CW'(1);
    assign push  = fifo_rvalid_i && !full;
    assign pop   = wvalid_o && wready_i;

    assign awid_o       = g_AXI_IDWIDTH'(g_AXI_ID);
    assign awsize_o     = 3'($clog2(g_DDR_AXI_DWIDTH / 8));
    assign awburst_o    = 2'b01;
    assign wstrb_o      = '1;
    assign awaddr_o     = addr_q;
    assign awlen_o      = len_q;
    assign awvalid_o    = awvalid_q;
    assign bready_o     = bready_q;
    assign write_ackn_o = ackn_q;
    assign write_done_o = done_q;
    assign busy_o       = (state_q != IDLE);
    assign buf_ovf_o    = ovf_q;
    assign wvalid_o     = (state_q == DATA) && !empty;
    assign wlast_o      = (state_q == DATA) && (beat_q == len_q);
    // Gate the head so an empty buffer never exposes stale or uninitialised RAM.
    assign wdata_o      = empty ? '0 : mem_q[rd_ptr_q];
    assign unused_in    = ^{bid_i, bresp_i};

    always_ff @(posedge sys_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= fifo_rdata_i;
    end

    always_ff @(posedge sys_clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (fifo_rvalid_i && full) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            ackn_q    <= 1'b0;
            done_q    <= 1'b0;
            awvalid_q <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            ackn_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Only accept once the whole burst fits, so W never underflows into a later push.
                    if (write_req_i && (free >= need)) begin
                        addr_q    <= write_start_addr_i;
                        len_q     <= write_length_i;
                        ackn_q    <= 1'b1;
                        awvalid_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (awready_i) begin
                        awvalid_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (pop) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == len_q) begin
                            bready_q <= 1'b1;
                            state_q  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bvalid_i) begin
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef WR_RESP_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge sys_clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_cnt_q <= '0;
        end else if (bvalid_i && bready_q && (bresp_i != 2'b00) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign resp_err_cnt_o = err_cnt_q;
`else
    assign resp_err_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_ddr_axi_write_master_enc.sv
// Directed bench for ddr_axi_write_master_enc: burst sequencing, backpressure, buffer admission,
// reset recovery and overflow, with a word queue as the data reference.
module tb_ddr_axi_write_master_enc;
    logic        sys_clk_i = 1'b0;
    logic        reset_i;
    logic        write_req_i;
    logic [31:0] write_start_addr_i;
    logic [7:0]  write_length_i;
    logic        write_ackn_o, write_done_o;
    logic [63:0] fifo_rdata_i;
    logic        fifo_rvalid_i;
    logic [3:0]  awid_o;
    logic [31:0] awaddr_o;
    logic [7:0]  awlen_o;
    logic [2:0]  awsize_o;
    logic [1:0]  awburst_o;
    logic        awvalid_o, awready_i;
    logic [63:0] wdata_o;
    logic [7:0]  wstrb_o;
    logic        wlast_o, wvalid_o, wready_i;
    logic [3:0]  bid_i;
    logic [1:0]  bresp_i;
    logic        bvalid_i, bready_o;
    logic        busy_o, buf_ovf_o;
    logic [15:0] resp_err_cnt_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];

    always #5 sys_clk_i = ~sys_clk_i;

    ddr_axi_write_master_enc dut (
        .sys_clk_i(sys_clk_i), .reset_i(reset_i),
        .write_req_i(write_req_i), .write_start_addr_i(write_start_addr_i),
        .write_length_i(write_length_i), .write_ackn_o(write_ackn_o), .write_done_o(write_done_o),
        .fifo_rdata_i(fifo_rdata_i), .fifo_rvalid_i(fifo_rvalid_i),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
        .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
        .wready_i(wready_i), .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i),
        .bready_o(bready_o), .busy_o(busy_o), .buf_ovf_o(buf_ovf_o),
        .resp_err_cnt_o(resp_err_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic push_words(input int n, input logic [31:0] tagw);
        for (int i = 0; i < n; i++) begin
            fifo_rvalid_i = 1'b1;
            fifo_rdata_i  = {tagw, 32'(i)};
            exp_q.push_back(fifo_rdata_i);
            tick();
        end
        fifo_rvalid_i = 1'b0;
    endtask

    // Holds a request for n cycles and expects no acceptance.
    task automatic req_no_ackn(input string tag, input logic [7:0] len, input int n);
        int acks = 0;
        write_req_i        = 1'b1;
        write_start_addr_i = 32'h0000_0800;
        write_length_i     = len;
        repeat (n) begin
            tick();
            if (write_ackn_o) acks++;
        end
        write_req_i = 1'b0;
        chk(tag, 64'(acks), 64'd0);
    endtask

    task automatic do_burst(input string tag, input logic [31:0] addr, input int len,
                            input int aw_dly, input bit tog, input logic [1:0] resp);
        int cyc = 0, beats = 0, acks = 0, dones = 0, aw_cyc = 0, aw_wait = 0;
        int gaps = 0, data_bad = 0, last_bad = 0, hold_bad = 0;
        int limit = 4 * (len + 1) + 60;
        bit aw_hs = 1'b0, stalled = 1'b0;
        logic [63:0] held = '0, exp_w;
        logic [31:0] aw_addr_s = '0;
        logic [7:0]  aw_len_s = '0;
        write_req_i        = 1'b1;
        write_start_addr_i = addr;
        write_length_i     = 8'(len);
        bresp_i            = resp;
        while (dones == 0 && cyc < limit) begin
            if (write_ackn_o) begin
                acks++;
                write_req_i = 1'b0;
            end
            if (write_done_o) begin
                dones++;
                bvalid_i  = 1'b0;
                wready_i  = 1'b0;
                awready_i = 1'b0;
                break;
            end
            if (stalled && !(wvalid_o && wdata_o == held)) hold_bad++;
            if (aw_hs && beats <= len && !wvalid_o) gaps++;
            if (awvalid_o) begin
                awready_i = (aw_wait >= aw_dly);
                aw_cyc++;
                aw_wait++;
                if (awready_i) begin
                    aw_hs     = 1'b1;
                    aw_addr_s = awaddr_o;
                    aw_len_s  = awlen_o;
                end
            end else begin
                awready_i = 1'b0;
            end
            wready_i = tog ? cyc[0] : 1'b1;
            stalled  = wvalid_o && !wready_i;
            held     = wdata_o;
            if (wvalid_o && wready_i) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
                if (wdata_o !== exp_w) data_bad++;
                if (wlast_o !== (beats == len)) last_bad++;
                beats++;
            end
            bvalid_i = bready_o;
            tick();
            cyc++;
        end
        write_req_i = 1'b0;
        chk({tag, ".timeout"}, 64'(dones), 64'd1);
        chk({tag, ".ackn"}, 64'(acks), 64'd1);
        chk({tag, ".awaddr"}, 64'(aw_addr_s), 64'(addr));
        chk({tag, ".awlen"}, 64'(aw_len_s), 64'(len));
        chk({tag, ".awvalid_cyc"}, 64'(aw_cyc), 64'(aw_dly + 1));
        chk({tag, ".beats"}, 64'(beats), 64'(len + 1));
        chk({tag, ".data"}, 64'(data_bad), 64'd0);
        chk({tag, ".wlast"}, 64'(last_bad), 64'd0);
        chk({tag, ".wvalid_gap"}, 64'(gaps), 64'd0);
        chk({tag, ".stall_hold"}, 64'(hold_bad), 64'd0);
        tick();
        chk({tag, ".done_pulse"}, 64'(write_done_o), 64'd0);
        chk({tag, ".busy_end"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        int acks;
        reset_i = 1'b1;
        write_req_i = 1'b0; write_start_addr_i = '0; write_length_i = '0;
        fifo_rdata_i = '0; fifo_rvalid_i = 1'b0;
        awready_i = 1'b0; wready_i = 1'b0;
        bid_i = 4'h5; bresp_i = 2'b00; bvalid_i = 1'b0;
        tick();
        tick();
        chk("rst.awsize", 64'(awsize_o), 64'd3);
        chk("rst.awburst", 64'(awburst_o), 64'd1);
        chk("rst.wstrb", 64'(wstrb_o), 64'hFF);
        chk("rst.awid", 64'(awid_o), 64'd0);
        chk("rst.valids", 64'({awvalid_o, wvalid_o, wlast_o, bready_o}), 64'd0);
        chk("rst.pulses", 64'({write_ackn_o, write_done_o, busy_o, buf_ovf_o}), 64'd0);
        chk("rst.awaddr", 64'(awaddr_o), 64'd0);
        chk("rst.wdata", wdata_o, 64'd0);
        chk("rst.errcnt", 64'(resp_err_cnt_o), 64'd0);
        reset_i = 1'b0;
        tick();

        push_words(8, 32'h1111_0000);
        do_burst("t1", 32'h0012_0800, 7, 0, 1'b0, 2'b00);

        push_words(256, 32'h2222_0000);
        do_burst("t2", 32'h0012_1000, 255, 0, 1'b1, 2'b00);
        chk("t2.no_ovf", 64'(buf_ovf_o), 64'd0);

        // 300 buffered: free 212 < 256, then free 255, then exactly 256.
        push_words(300, 32'h3333_0000);
        req_no_ackn("t3.withheld_300", 8'd255, 20);
        do_burst("t3.drain43", 32'h0012_1800, 42, 0, 1'b0, 2'b00);
        req_no_ackn("t3.withheld_257", 8'd255, 10);
        do_burst("t4.len0", 32'h0012_2000, 0, 5, 1'b0, 2'b00);
        do_burst("t3.full256", 32'h0012_2800, 255, 0, 1'b0, 2'b00);

        push_words(2, 32'h5555_0000);
        do_burst("t5.a", 32'h0012_3000, 1, 0, 1'b0, 2'b10);
        push_words(2, 32'h5555_1000);
        do_burst("t5.b", 32'h0012_3800, 1, 1, 1'b0, 2'b10);
`ifdef WR_RESP_ERR_CNT_EN
        chk("t5.errcnt", 64'(resp_err_cnt_o), 64'd2);
`else
        chk("t5.errcnt", 64'(resp_err_cnt_o), 64'd0);
`endif

        // Reset in the middle of a data phase.
        push_words(16, 32'h6666_0000);
        write_req_i = 1'b1; write_start_addr_i = 32'h0012_4000; write_length_i = 8'd15;
        acks = 0;
        for (int i = 0; i < 20 && acks == 0; i++) begin
            tick();
            if (write_ackn_o) acks++;
        end
        chk("t6.ackn", 64'(acks), 64'd1);
        write_req_i = 1'b0;
        awready_i = 1'b1;
        tick();
        awready_i = 1'b0;
        wready_i = 1'b1;
        repeat (3) tick();
        chk("t6.mid_data", 64'(wvalid_o), 64'd1);
        #2 reset_i = 1'b1;
        #1;
        chk("t6.async_valids", 64'({awvalid_o, wvalid_o, wlast_o, bready_o}), 64'd0);
        chk("t6.async_busy", 64'(busy_o), 64'd0);
        chk("t6.flushed", wdata_o, 64'd0);
        wready_i = 1'b0;
        exp_q.delete();
        tick();
        reset_i = 1'b0;
        tick();
        push_words(4, 32'h6666_1000);
        do_burst("t6.fresh", 32'h0012_4800, 3, 0, 1'b0, 2'b00);

        // Overflow: 513 pushes into a 512-deep buffer.
        push_words(513, 32'h7777_0000);
        tick();
        chk("t7.ovf", 64'(buf_ovf_o), 64'd1);
        tick();
        chk("t7.ovf_sticky", 64'(buf_ovf_o), 64'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        exp_q.delete();
        tick();
        chk("t7.ovf_cleared", 64'(buf_ovf_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
